// File: rtl/reg_file_pkg.sv
// Shared constants and clear-sequencer state encoding for the 2R1W register file.
package reg_file_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefAddrW = 3;

    // Clear-sequencer states, 2-bit encoding.
    typedef logic [1:0] clr_state_t;

    localparam clr_state_t StIdle  = 2'd0;
    localparam clr_state_t StClear = 2'd1;
    localparam clr_state_t StDone  = 2'd2;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Soft-clear sequencer: walks every entry once, emitting a zero-write strobe per cycle.
module reg_file_clr_seq
    import reg_file_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr_req_i,
    output logic              clr_busy_o,
    output logic              clr_done_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // Next-state and counter update; the counter wraps naturally at DEPTH.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (clr_req_i) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                cnt_d = cnt_q + ADDR_W'(1);
                // All-ones count is the last entry.
                if (&cnt_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status and strobe decoded purely from registered state.
    always_comb begin
        clr_busy_o = (state_q == StClear);
        clr_done_o = (state_q == StDone);
        clr_we_o   = (state_q == StClear);
        clr_addr_o = cnt_q;
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with byte enables, write-to-read forwarding,
// optional hard-wired zero entry and a sequential soft-clear engine.
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                we,
    input  logic [ADDR_W-1:0]   wAddr,
    input  logic [DATA_W-1:0]   wData,
    input  logic [DATA_W/8-1:0] wBe,
    input  logic [ADDR_W-1:0]   rAddr0,
    output logic [DATA_W-1:0]   rData0,
    input  logic [ADDR_W-1:0]   rAddr1,
    output logic [DATA_W-1:0]   rData1,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done
);

    localparam int unsigned Depth    = 2 ** ADDR_W;
    localparam int unsigned NumBytes = DATA_W / 8;
    localparam bit          ZeroEn   = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem_q [Depth];
    logic [DATA_W-1:0] mem_d [Depth];
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_acc;
    logic [DATA_W-1:0] be_mask;
    logic [DATA_W-1:0] merged;

    reg_file_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_req_i  (clr_req),
        .clr_busy_o (clr_busy),
        .clr_done_o (clr_done),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    // Write acceptance and byte merge against the current entry contents.
    always_comb begin
        wr_acc = we && !clr_busy && !(ZeroEn && (wAddr == '0));
        for (int i = 0; i < int'(NumBytes); i++) begin
            be_mask[8*i +: 8] = {8{wBe[i]}};
        end
        merged = (mem_q[wAddr] & ~be_mask) | (wData & be_mask);
    end

    // Storage next state: clear strobe and port writes are mutually exclusive.
    always_comb begin
        mem_d = mem_q;
        if (clr_we) begin
            mem_d[clr_addr] = '0;
        end else if (wr_acc) begin
            mem_d[wAddr] = merged;
        end
    end

    // Read port 0: zero during clear, zero entry, forwarded merge, else stored word.
    always_comb begin
        if (clr_busy || (ZeroEn && (rAddr0 == '0))) begin
            rdata0_d = '0;
        end else if (wr_acc && (wAddr == rAddr0)) begin
            rdata0_d = merged;
        end else begin
            rdata0_d = mem_q[rAddr0];
        end
    end

    // Read port 1: same selection as port 0.
    always_comb begin
        if (clr_busy || (ZeroEn && (rAddr1 == '0))) begin
            rdata1_d = '0;
        end else if (wr_acc && (wAddr == rAddr1)) begin
            rdata1_d = merged;
        end else begin
            rdata1_d = mem_q[rAddr1];
        end
    end

    // Storage and registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            mem_q    <= mem_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Drive read outputs from their registers.
    always_comb begin
        rData0 = rdata0_q;
        rData1 = rdata1_q;
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: one instance without and one with the zero entry.
module tb_reg_file_2r1w;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        we = 1'b0;
    logic        clr_req = 1'b0;
    logic [2:0]  wAddr = '0, rAddr0 = '0, rAddr1 = '0;
    logic [31:0] wData = '0;
    logic [3:0]  wBe = '0;

    logic [31:0] rdata0, rdata1, z_rdata0, z_rdata1;
    logic        busy, done, z_busy, z_done;

    reg_file_2r1w #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0)) dut (
        .clk(clk), .reset_n(reset_n), .we(we), .wAddr(wAddr), .wData(wData), .wBe(wBe),
        .rAddr0(rAddr0), .rData0(rdata0), .rAddr1(rAddr1), .rData1(rdata1),
        .clr_req(clr_req), .clr_busy(busy), .clr_done(done)
    );

    reg_file_2r1w #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset_n(reset_n), .we(we), .wAddr(wAddr), .wData(wData), .wBe(wBe),
        .rAddr0(rAddr0), .rData0(z_rdata0), .rAddr1(rAddr1), .rData1(z_rdata1),
        .clr_req(clr_req), .clr_busy(z_busy), .clr_done(z_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          sel;
        int          tag;
        logic [31:0] val;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    int    tnum = 0;
    string names[8] = '{"rData0", "rData1", "clr_busy", "clr_done",
                        "z.rData0", "z.rData1", "z.clr_busy", "z.clr_done"};

    function automatic logic [31:0] actual(int sel);
        case (sel)
            0: return rdata0;
            1: return rdata1;
            2: return {31'd0, busy};
            3: return {31'd0, done};
            4: return z_rdata0;
            5: return z_rdata1;
            6: return {31'd0, z_busy};
            default: return {31'd0, z_done};
        endcase
    endfunction

    function automatic void push(int due, int sel, logic [31:0] val);
        exp_t e;
        e.due = due;
        e.sel = sel;
        e.tag = tnum;
        e.val = val;
        sb.push_back(e);
    endfunction

    // Monitor: compare every expectation that falls due in this cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] a;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            a = actual(e.sel);
            checks++;
            if (e.due != cyc) begin
                errors++;
                $display("FAIL t%0d %s stale: due cycle %0d seen at %0d", e.tag, names[e.sel],
                         e.due, cyc);
            end else if (a !== e.val) begin
                errors++;
                $display("FAIL t%0d %s cycle %0d: got %h expected %h", e.tag, names[e.sel],
                         cyc, a, e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; wAddr = 3'(i); wData = base + 32'(i); wBe = 4'hF;
            step();
        end
        we = 1'b0;
    endtask

    task automatic read_all_zero();
        for (int a = 0; a < 8; a++) begin
            rAddr0 = 3'(a); rAddr1 = 3'(7 - a);
            push(cyc + 1, 0, 32'd0); push(cyc + 1, 1, 32'd0);
            push(cyc + 1, 4, 32'd0); push(cyc + 1, 5, 32'd0);
            step();
        end
    endtask

    initial begin
        int c;
        int w;
        logic [31:0] ev;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state.
        tnum = 0;
        for (int s = 0; s < 8; s++) push(cyc, s, 32'd0);
        step();

        // Sequential writes 1..6, dropped write to 7, read back 0..7.
        tnum = 1;
        for (int i = 1; i <= 6; i++) begin
            we = 1'b1; wAddr = 3'(i); wData = 32'(i); wBe = 4'hF;
            step();
        end
        we = 1'b0; wAddr = 3'd7; wData = 32'd7;
        for (int a = 0; a < 8; a++) begin
            rAddr0 = 3'(a);
            ev = (a >= 1 && a <= 6) ? 32'(a) : 32'd0;
            push(cyc + 1, 0, ev); push(cyc + 1, 4, ev);
            step();
        end

        // Byte-enable merge.
        tnum = 2;
        we = 1'b1; wAddr = 3'd3; wData = 32'hAABBCCDD; wBe = 4'hF;
        step();
        wData = 32'h11223344; wBe = 4'b0101;
        step();
        we = 1'b0; rAddr0 = 3'd3;
        push(cyc + 1, 0, 32'hAA22CC44); push(cyc + 1, 4, 32'hAA22CC44);
        step();

        // Forwarding to both ports, partial then full.
        tnum = 3;
        we = 1'b1; wAddr = 3'd5; wData = 32'h12345678; wBe = 4'hF;
        step();
        wData = 32'hDEADBEEF; wBe = 4'b0011; rAddr0 = 3'd5; rAddr1 = 3'd5;
        for (int s = 0; s < 2; s++) begin
            push(cyc + 1, s, 32'h1234BEEF); push(cyc + 1, s + 4, 32'h1234BEEF);
        end
        step();
        wBe = 4'hF;
        for (int s = 0; s < 2; s++) begin
            push(cyc + 1, s, 32'hDEADBEEF); push(cyc + 1, s + 4, 32'hDEADBEEF);
        end
        step();
        we = 1'b0;
        for (int s = 0; s < 2; s++) begin
            push(cyc + 1, s, 32'hDEADBEEF); push(cyc + 1, s + 4, 32'hDEADBEEF);
        end
        step();

        // Zero entry: write to addr 0 ignored only on the ZERO_REG instance.
        tnum = 4;
        we = 1'b1; wAddr = 3'd0; wData = 32'hFFFFFFFF; wBe = 4'hF;
        rAddr0 = 3'd0; rAddr1 = 3'd1;
        for (int k = 0; k < 2; k++) begin
            push(cyc + 1, 0, 32'hFFFFFFFF); push(cyc + 1, 1, 32'd1);
            push(cyc + 1, 4, 32'd0);        push(cyc + 1, 5, 32'd1);
            step();
            we = 1'b0;
        end

        // Full soft clear with a dropped mid-clear write.
        tnum = 5;
        fill(32'hA0);
        rAddr0 = 3'd1; rAddr1 = 3'd2;
        clr_req = 1'b1;
        c = cyc;
        for (int d = 0; d <= 10; d++) begin
            push(c + d, 2, (d >= 1 && d <= 8) ? 32'd1 : 32'd0);
            push(c + d, 3, (d == 9) ? 32'd1 : 32'd0);
            push(c + d, 6, (d >= 1 && d <= 8) ? 32'd1 : 32'd0);
            push(c + d, 7, (d == 9) ? 32'd1 : 32'd0);
            if (d >= 1 && d <= 9) begin
                push(c + d, 0, (d == 1) ? 32'hA1 : 32'd0);
                push(c + d, 1, (d == 1) ? 32'hA2 : 32'd0);
                push(c + d, 4, (d == 1) ? 32'hA1 : 32'd0);
                push(c + d, 5, (d == 1) ? 32'hA2 : 32'd0);
            end
        end
        step();
        clr_req = 1'b0;
        step();
        step();
        we = 1'b1; wAddr = 3'd0; wData = 32'hFFFFFFFF; wBe = 4'hF;
        step();
        we = 1'b0;
        w = 0;
        while (cyc < c + 10 && w < 20) begin
            step();
            w++;
        end
        read_all_zero();

        // Reset in the middle of a clear.
        tnum = 6;
        fill(32'hB0);
        clr_req = 1'b1;
        c = cyc;
        for (int d = 0; d <= 12; d++) begin
            push(c + d, 2, (d == 1 || d == 2) ? 32'd1 : 32'd0);
            push(c + d, 3, 32'd0);
            push(c + d, 6, (d == 1 || d == 2) ? 32'd1 : 32'd0);
            push(c + d, 7, 32'd0);
        end
        step();
        clr_req = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        w = 0;
        while (cyc < c + 12 && w < 20) begin
            step();
            w++;
        end
        read_all_zero();

        // Drain the scoreboard with a bounded wait.
        w = 0;
        while (sb.size() > 0 && w < 20) begin
            step();
            w++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
